// File: rtl/cpl2ibuff.sv
// Parses CplD TLPs from the 64-bit TRN rx stream into the internal buffer and notifies the gc instances.
// Optional completion counters are built only when CPL2IBUFF_STATS_EN is defined.
module cpl2ibuff #(
  parameter int BW        = 9,
  parameter int SLOT_QW_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   trn_rd,
  input  logic [7:0]    trn_rrem_n,
  input  logic          trn_rsof_n,
  input  logic          trn_reof_n,
  input  logic          trn_rsrc_rdy_n,
  input  logic          trn_rerrfwd_n,
  input  logic [6:0]    trn_rbar_hit_n,
  input  logic [15:0]   cfg_completer_id,
  output logic [BW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          wr_en,
  output logic          cpl1_rcved,
  output logic          cpl2_rcved,
  output logic [9:0]    cpl_dws,
  output logic [4:0]    cpl_tag,
  output logic [31:0]   stat_good,
  output logic [31:0]   stat_drop
);

  localparam int TAG_W = BW - SLOT_QW_W;
  localparam logic [SLOT_QW_W-1:0] COL_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR2 = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Handshake: a beat is any cycle with trn_rsrc_rdy_n low. There is no ready
  // signal in the other direction; every beat is consumed in the cycle it appears.
  logic        w_beat;
  logic        w_sof;
  logic        w_eof;
  logic        w_err;
  logic        w_full;
  logic [31:0] w_dh;
  logic [31:0] w_dl;
  logic        w_hdr_ok;
  logic        w_rid_ok;

  assign w_beat   = ~trn_rsrc_rdy_n;
  assign w_sof    = w_beat & ~trn_rsof_n;
  assign w_eof    = w_beat & ~trn_reof_n;
  assign w_err    = ~trn_rerrfwd_n;
  assign w_full   = (trn_rrem_n == 8'h00);
  assign w_dh     = trn_rd[63:32];
  assign w_dl     = trn_rd[31:0];
  assign w_hdr_ok = (w_dh[30:24] == 7'b1001010) && (w_dl[15:13] == 3'b000) &&
                    (trn_rbar_hit_n == 7'h7F) && !w_err && !w_eof;
  assign w_rid_ok = (w_dh[31:16] == cfg_completer_id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_beat) begin
      if (w_sof) begin
        w_next = w_hdr_ok ? S_HDR2 : (w_eof ? S_IDLE : S_DROP);
      end else begin
        case (r_state)
          S_IDLE: w_next = S_IDLE;
          S_HDR2: begin
            if (w_err || !w_rid_ok) w_next = w_eof ? S_IDLE : S_DROP;
            else                    w_next = w_eof ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            if (w_err) w_next = w_eof ? S_IDLE : S_DROP;
            else       w_next = w_eof ? S_IDLE : S_DATA;
          end
          S_DROP:  w_next = w_eof ? S_IDLE : S_DROP;
          default: w_next = S_IDLE;
        endcase
      end
    end
  end

  // Per-beat actions decoded from the current state and beat.
  logic w_hdr_lat;
  logic w_hdr2_acc;
  logic w_data_wr;
  logic w_fl_set;
  logic w_ntf_now;

  always_comb begin
    w_hdr_lat  = 1'b0;
    w_hdr2_acc = 1'b0;
    w_data_wr  = 1'b0;
    w_fl_set   = 1'b0;
    w_ntf_now  = 1'b0;
    if (w_beat) begin
      if (w_sof) begin
        w_hdr_lat = w_hdr_ok;
      end else begin
        case (r_state)
          S_HDR2: begin
            if (!w_err && w_rid_ok) begin
              w_hdr2_acc = 1'b1;
              w_fl_set   = w_eof && w_full;
            end
          end
          S_DATA: begin
            if (!w_err) begin
              w_data_wr = 1'b1;
              w_fl_set  = w_eof && w_full;
              w_ntf_now = w_eof && !w_full;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [9:0]           r_len;
  logic [TAG_W-1:0]     r_tag;
  logic [SLOT_QW_W-1:0] r_off;
  logic [SLOT_QW_W-1:0] r_idx;
  logic [31:0]          r_held;

  logic [SLOT_QW_W-1:0] w_col;
  logic [SLOT_QW_W-1:0] w_cur_col;
  logic [TAG_W-1:0]     w_cur_tag;

  // A length-1 TLP ends on the HDR2 beat, so tag and column come from the beat itself there.
  assign w_col     = r_off + r_idx;
  assign w_cur_tag = (r_state == S_HDR2) ? w_dh[8 +: TAG_W] : r_tag;
  assign w_cur_col = (r_state == S_HDR2) ? w_dh[3 +: SLOT_QW_W] : (w_col + COL_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_tag  <= '0;
      r_off  <= '0;
      r_idx  <= '0;
      r_held <= '0;
    end else begin
      if (w_hdr_lat) r_len <= w_dh[9:0];
      if (w_hdr2_acc) begin
        r_tag  <= w_dh[8 +: TAG_W];
        r_off  <= w_dh[3 +: SLOT_QW_W];
        r_idx  <= '0;
        r_held <= w_dl;
      end
      if (w_data_wr) begin
        r_idx  <= r_idx + COL_ONE;
        r_held <= w_dl;
      end
    end
  end

  logic          r_wr_en;
  logic [BW-1:0] r_wr_addr;
  logic [63:0]   r_wr_data;
  logic          r_fl_pend;
  logic [BW-1:0] r_fl_addr;
  logic [63:0]   r_fl_data;
  logic          r_ntf_pend;
  logic [TAG_W-1:0] r_ntf_tag;
  logic [9:0]    r_ntf_len;

  // The flush write owns the port: a TLP never writes on the beat after its predecessor's eof.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_fl_pend  <= 1'b0;
      r_fl_addr  <= '0;
      r_fl_data  <= '0;
      r_ntf_pend <= 1'b0;
      r_ntf_tag  <= '0;
      r_ntf_len  <= '0;
    end else begin
      r_wr_en    <= 1'b0;
      r_ntf_pend <= w_ntf_now;
      if (r_fl_pend) begin
        r_wr_en    <= 1'b1;
        r_wr_addr  <= r_fl_addr;
        r_wr_data  <= r_fl_data;
        r_ntf_pend <= 1'b1;
      end else if (w_data_wr) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= {r_tag, w_col};
        r_wr_data <= {r_held, w_dh};
      end
      r_fl_pend <= w_fl_set;
      if (w_fl_set) begin
        r_fl_addr <= {w_cur_tag, w_cur_col};
        r_fl_data <= {w_dl, 32'h0};
      end
      if (w_fl_set || w_ntf_now) begin
        r_ntf_tag <= w_cur_tag;
        r_ntf_len <= r_len;
      end
    end
  end

  logic             r_cpl1;
  logic             r_cpl2;
  logic [9:0]       r_cpl_dws;
  logic [TAG_W-1:0] r_cpl_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpl1    <= 1'b0;
      r_cpl2    <= 1'b0;
      r_cpl_dws <= '0;
      r_cpl_tag <= '0;
    end else begin
      r_cpl1 <= r_ntf_pend & ~r_ntf_tag[TAG_W-1];
      r_cpl2 <= r_ntf_pend &  r_ntf_tag[TAG_W-1];
      if (r_ntf_pend) begin
        r_cpl_dws <= r_ntf_len;
        r_cpl_tag <= r_ntf_tag;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cpl1_rcved = r_cpl1;
  assign cpl2_rcved = r_cpl2;
  assign cpl_dws    = r_cpl_dws;
  assign cpl_tag    = r_cpl_tag;

`ifdef CPL2IBUFF_STATS_EN
  // One drop per TLP: header rejects and error-forwarded beats in a live TLP.
  logic        w_drop_evt;
  logic [31:0] r_good;
  logic [31:0] r_drop;

  assign w_drop_evt = w_beat & ((w_sof & ~w_hdr_ok) |
                                (~w_sof & (r_state == S_HDR2) & (w_err | ~w_rid_ok)) |
                                (~w_sof & (r_state == S_DATA) & w_err));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_good <= '0;
      r_drop <= '0;
    end else begin
      if (r_ntf_pend) r_good <= r_good + 32'd1;
      if (w_drop_evt) r_drop <= r_drop + 32'd1;
    end
  end

  assign stat_good = r_good;
  assign stat_drop = r_drop;
`else
  assign stat_good = 32'd0;
  assign stat_drop = 32'd0;
`endif

endmodule

// File: tb/tb_cpl2ibuff.sv
// Directed bench for cpl2ibuff: hand-computed write/notify expectations checked with immediate assertions.
module tb_cpl2ibuff;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rerrfwd_n;
  logic [6:0]  trn_rbar_hit_n;
  logic [15:0] cfg_completer_id;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_en;
  logic        cpl1_rcved;
  logic        cpl2_rcved;
  logic [9:0]  cpl_dws;
  logic [4:0]  cpl_tag;
  logic [31:0] stat_good;
  logic [31:0] stat_drop;

  cpl2ibuff dut (
    .clk(clk), .rst(rst),
    .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rerrfwd_n(trn_rerrfwd_n), .trn_rbar_hit_n(trn_rbar_hit_n),
    .cfg_completer_id(cfg_completer_id),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .cpl1_rcved(cpl1_rcved), .cpl2_rcved(cpl2_rcved), .cpl_dws(cpl_dws), .cpl_tag(cpl_tag),
    .stat_good(stat_good), .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [72:0] obs_w[$];
  logic [72:0] exp_q[$];
  time         obs_wt[$];
  time         exp_wt[$];
  logic [16:0] obs_n[$];
  logic [16:0] exp_n[$];
  time         obs_nt[$];
  time         exp_nt[$];
  time         bt[$];

  // Outputs are registered, so sampling on the falling edge sees stable values.
  always @(negedge clk) begin
    if (wr_en) begin
      obs_w.push_back({wr_addr, wr_data});
      obs_wt.push_back($time);
    end
    if (cpl1_rcved || cpl2_rcved) begin
      obs_n.push_back({cpl1_rcved, cpl2_rcved, cpl_tag, cpl_dws});
      obs_nt.push_back($time);
    end
  end

  function automatic logic [31:0] dw(input int s, input int i);
    return 32'hC0DE0000 + 32'(s * 256 + i);
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic clear_q();
    obs_w.delete(); obs_wt.delete(); exp_q.delete(); exp_wt.delete();
    obs_n.delete(); obs_nt.delete(); exp_n.delete(); exp_nt.delete();
    bt.delete();
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic sof, input logic eof,
                            input logic [7:0] rrem, input logic err);
    @(negedge clk);
    trn_rd         = d;
    trn_rsof_n     = ~sof;
    trn_reof_n     = ~eof;
    trn_rrem_n     = rrem;
    trn_rerrfwd_n  = ~err;
    trn_rsrc_rdy_n = 1'b0;
    bt.push_back($time);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      trn_rsrc_rdy_n = 1'b1;
      trn_rsof_n     = 1'b1;
      trn_reof_n     = 1'b1;
      trn_rerrfwd_n  = 1'b1;
    end
  endtask

  task automatic send_tlp(input logic [6:0] ft, input int tag, input int len, input logic [6:0] la,
                          input logic [15:0] rid, input logic [2:0] st, input logic err_last,
                          input int nb_max);
    int          nb;
    logic [31:0] h0, h1, h2, lo;
    logic [63:0] d;
    logic        e;
    logic [7:0]  last_rrem;
    nb        = 2 + len / 2;
    h0        = {1'b0, ft, 14'h0, 10'(len)};
    h1        = {16'h0100, st, 1'b0, 12'(len * 4)};
    h2        = {rid, 8'(tag), 1'b0, la};
    last_rrem = (len % 2 == 1) ? 8'h00 : 8'h0F;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)      d = {h0, h1};
      else if (b == 1) d = {h2, dw(tag, 0)};
      else begin
        lo = (2 * b - 2 < len) ? dw(tag, 2 * b - 2) : 32'hDEADBEEF;
        d  = {dw(tag, 2 * b - 3), lo};
      end
      e = (b == nb - 1);
      if (nb_max == 0 || b < nb_max)
        drive_beat(d, b == 0, e, e ? last_rrem : 8'h00, e & err_last);
    end
  endtask

  task automatic check_all(input string name);
    chk({name, " wr_cnt"}, 128'(obs_w.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_w.size()) begin
        chk($sformatf("%s wr%0d", name, i), obs_w[i], exp_q[i]);
        chk($sformatf("%s wr%0d_time", name, i), obs_wt[i], exp_wt[i]);
      end
    end
    chk({name, " ntf_cnt"}, 128'(obs_n.size()), 128'(exp_n.size()));
    for (int i = 0; i < exp_n.size(); i++) begin
      if (i < obs_n.size()) begin
        chk($sformatf("%s ntf%0d", name, i), obs_n[i], exp_n[i]);
        chk($sformatf("%s ntf%0d_time", name, i), obs_nt[i], exp_nt[i]);
      end
    end
    clear_q();
  endtask

  initial begin
    rst              = 1'b1;
    trn_rd           = '0;
    trn_rrem_n       = 8'h00;
    trn_rsof_n       = 1'b1;
    trn_reof_n       = 1'b1;
    trn_rsrc_rdy_n   = 1'b1;
    trn_rerrfwd_n    = 1'b1;
    trn_rbar_hit_n   = 7'h7F;
    cfg_completer_id = 16'h0200;

    repeat (3) @(negedge clk);
    chk("reset wr", {wr_en, wr_addr, wr_data}, '0);
    chk("reset cpl", {cpl1_rcved, cpl2_rcved, cpl_tag, cpl_dws}, '0);
    chk("reset stat", {stat_good, stat_drop}, '0);
    rst = 1'b0;
    idle(2);
    clear_q();

    // tag 3, length 4, lower address 0x00
    send_tlp(7'h4A, 3, 4, 7'h00, 16'h0200, 3'b000, 1'b0, 0);
    idle(5);
    exp_q.push_back({9'h030, dw(3, 0), dw(3, 1)}); exp_wt.push_back(bt[2] + 10);
    exp_q.push_back({9'h031, dw(3, 2), dw(3, 3)}); exp_wt.push_back(bt[3] + 10);
    exp_n.push_back({1'b1, 1'b0, 5'd3, 10'd4});    exp_nt.push_back(bt[3] + 20);
    check_all("cpl_t3");
    chk("cpl_t3 held", {cpl1_rcved, cpl2_rcved, cpl_tag, cpl_dws}, {1'b0, 1'b0, 5'd3, 10'd4});

    // tag 17, length 3, lower address 0x40: odd length ends with a flush write
    send_tlp(7'h4A, 17, 3, 7'h40, 16'h0200, 3'b000, 1'b0, 0);
    idle(5);
    exp_q.push_back({9'h118, dw(17, 0), dw(17, 1)}); exp_wt.push_back(bt[2] + 10);
    exp_q.push_back({9'h119, dw(17, 2), 32'h0});     exp_wt.push_back(bt[2] + 20);
    exp_n.push_back({1'b0, 1'b1, 5'd17, 10'd3});     exp_nt.push_back(bt[2] + 30);
    check_all("cpl_t17");

    // tag 5, lower address 0x78: column wraps inside the slot
    send_tlp(7'h4A, 5, 4, 7'h78, 16'h0200, 3'b000, 1'b0, 0);
    idle(5);
    exp_q.push_back({9'h05F, dw(5, 0), dw(5, 1)}); exp_wt.push_back(bt[2] + 10);
    exp_q.push_back({9'h050, dw(5, 2), dw(5, 3)}); exp_wt.push_back(bt[3] + 10);
    exp_n.push_back({1'b1, 1'b0, 5'd5, 10'd4});    exp_nt.push_back(bt[3] + 20);
    check_all("cpl_wrap");

    // odd-length eof immediately followed by a new sof
    send_tlp(7'h4A, 9, 5, 7'h10, 16'h0200, 3'b000, 1'b0, 0);
    send_tlp(7'h4A, 18, 2, 7'h00, 16'h0200, 3'b000, 1'b0, 0);
    idle(6);
    exp_q.push_back({9'h092, dw(9, 0), dw(9, 1)});   exp_wt.push_back(bt[2] + 10);
    exp_q.push_back({9'h093, dw(9, 2), dw(9, 3)});   exp_wt.push_back(bt[3] + 10);
    exp_q.push_back({9'h094, dw(9, 4), 32'h0});      exp_wt.push_back(bt[3] + 20);
    exp_q.push_back({9'h120, dw(18, 0), dw(18, 1)}); exp_wt.push_back(bt[6] + 10);
    exp_n.push_back({1'b1, 1'b0, 5'd9, 10'd5});      exp_nt.push_back(bt[3] + 30);
    exp_n.push_back({1'b0, 1'b1, 5'd18, 10'd2});     exp_nt.push_back(bt[6] + 20);
    check_all("b2b_flush");

    // requester ID mismatch, bad status, MemWr: all discarded
    send_tlp(7'h4A, 4, 2, 7'h00, 16'h0BAD, 3'b000, 1'b0, 0);
    send_tlp(7'h4A, 4, 2, 7'h00, 16'h0200, 3'b001, 1'b0, 0);
    send_tlp(7'h40, 4, 2, 7'h00, 16'h0200, 3'b000, 1'b0, 0);
    idle(5);
    check_all("drops");

    // error forwarded on eof: earlier write stays, no notify
    send_tlp(7'h4A, 6, 4, 7'h00, 16'h0200, 3'b000, 1'b1, 0);
    idle(5);
    chk("errfwd wr0", (obs_w.size() > 0) ? obs_w[0] : 73'bx, {9'h060, dw(6, 0), dw(6, 1)});
    chk("errfwd ntf_cnt", 128'(obs_n.size()), 128'd0);
    chk("errfwd held", {cpl_tag, cpl_dws}, {5'd18, 10'd2});
    clear_q();

`ifdef CPL2IBUFF_STATS_EN
    chk("stats", {stat_good, stat_drop}, {32'd5, 32'd4});
`else
    chk("stats", {stat_good, stat_drop}, 64'd0);
`endif

    // reset in the middle of a TLP
    send_tlp(7'h4A, 7, 4, 7'h00, 16'h0200, 3'b000, 1'b0, 3);
    @(posedge clk);
    #1;
    chk("pre_rst wr", {wr_en, wr_addr}, {1'b1, 9'h070});
    #1 rst = 1'b1;
    #1;
    chk("mid_rst wr", {wr_en, wr_addr, wr_data}, '0);
    chk("mid_rst cpl", {cpl1_rcved, cpl2_rcved, cpl_tag, cpl_dws}, '0);
    chk("mid_rst stat", {stat_good, stat_drop}, '0);
    idle(2);
    rst = 1'b0;
    clear_q();
    drive_beat({dw(7, 3), 32'hDEADBEEF}, 1'b0, 1'b1, 8'h0F, 1'b0);
    idle(4);
    check_all("rst_tail");

    // first TLP after reset is processed normally
    send_tlp(7'h4A, 20, 2, 7'h08, 16'h0200, 3'b000, 1'b0, 0);
    idle(5);
    exp_q.push_back({9'h141, dw(20, 0), dw(20, 1)}); exp_wt.push_back(bt[2] + 10);
    exp_n.push_back({1'b0, 1'b1, 5'd20, 10'd2});     exp_nt.push_back(bt[2] + 20);
    check_all("post_rst");

`ifdef CPL2IBUFF_STATS_EN
    chk("stats_final", {stat_good, stat_drop}, {32'd1, 32'd0});
`else
    chk("stats_final", {stat_good, stat_drop}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpl2ibuff.md
CPL2IBUFF -- requirements
Module: cpl2ibuff

Interface
REQ-001 Parameter BW, default 9: internal-buffer qword address width; SHALL equal 9.
REQ-002 Parameter SLOT_QW_W, default 4: log2 qwords per tag slot (128 B).
REQ-003 clk  in  1  sole clock, all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 trn_rd  in  64; trn_rrem_n  in  8; trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rerrfwd_n  in  1 each; trn_rbar_hit_n  in  7: TRN rx stream.
REQ-006 cfg_completer_id  in  16  own requester ID.
REQ-007 wr_addr  out  BW; wr_data  out  64; wr_en  out  1: internal-buffer write port.
REQ-008 cpl1_rcved, cpl2_rcved  out  1 each; cpl_dws  out  10; cpl_tag  out  5: completion notify to gc instances.
REQ-009 stat_good, stat_drop  out  32 each: completion counters (see Configuration).

Function
REQ-010 Block SHALL accept every beat with trn_rsrc_rdy_n low; there is no backpressure.
REQ-011 FSM states IDLE, HDR2, DATA, DROP; sof beat in any state restarts parsing.
REQ-012 IDLE, sof beat: accept iff DW0[30:24]=7'b1001010 (CplD), DW1[15:13]=0, trn_rbar_hit_n=7'h7F; latch length=DW0[9:0]; go HDR2, else DROP.
REQ-013 HDR2: accept iff DW2[31:16]=cfg_completer_id; latch tag=DW2[15:8][4:0], qw offset=DW2[6:3]; hold D0=beat[31:0]; go DATA, else DROP.
REQ-014 DATA beat, upper DW Dh and lower DW Dl: write {held,Dh}; if rrem_n=8'h00, hold Dl.
REQ-015 eof beat with rrem_n=8'h0F: write {held,Dh}, nothing held; eof with rrem_n=8'h00 (odd length): next cycle flush write {held,32'h0}.
REQ-016 Flush SHALL complete even if the next cycle carries a new sof beat (sof beats never write).
REQ-017 wr_addr = {tag, offset + n}, n = write index within TLP; offset sum wraps modulo 16 inside slot.
REQ-018 wr_en/wr_addr/wr_data registered: one cycle after the producing beat (flush: two).
REQ-019 Cycle after the TLP's last wr_en: one-cycle pulse on cpl1_rcved if tag[4]=0 else cpl2_rcved, cpl_dws=length, cpl_tag=tag, both held until next pulse.
REQ-020 trn_rerrfwd_n low on any beat: suppress the notify pulse and go DROP; writes already issued are not retracted.
REQ-021 eof without sof-initiated header (IDLE/DROP): ignored, return IDLE.
REQ-022 DROP: discard beats until eof, then IDLE; no writes, no notify.
REQ-023 length=0 encodes 1024 DW; cpl_dws outputs raw field.

Reset
REQ-024 rst high SHALL immediately force IDLE, wr_en=0, wr_addr=0, wr_data=0, cpl1_rcved=cpl2_rcved=0, cpl_dws=0, cpl_tag=0, stat_*=0, pending flush cleared.
REQ-025 Reset mid-TLP: remaining beats after release treated as non-sof and ignored until next sof.

Configuration
REQ-026 Macro CPL2IBUFF_STATS_EN defined: stat_good increments per notify pulse, stat_drop per dropped TLP (REQ-012/013/020), both wrap at 2^32.
REQ-027 Macro undefined: counters not built, stat_good=stat_drop=0 constantly.

Verification
REQ-028 CplD tag 3, length 4, lower addr 0x00 -> writes addr 0x030..0x031 data {D0,D1},{D2,D3}; cpl1_rcved pulse, cpl_dws=4.
REQ-029 CplD tag 17, length 3, lower addr 0x40 -> writes 0x118 {D0,D1}, 0x119 {D2,0} (flush); cpl2_rcved pulse.
REQ-030 CplD tag 5, length 4, lower addr 0x78 -> addresses 0x05F then 0x050 (slot wrap).
REQ-031 Requester ID mismatch, then status=3'b001, then MemWr TLP -> no wr_en, no notify; stat_drop=3 with macro.
REQ-032 trn_rerrfwd_n low on eof of length-4 CplD -> writes occur, no notify; rst pulse mid-TLP -> outputs zero, next valid CplD processed normally.
REQ-033 Odd-length CplD eof immediately followed by sof -> flush write and new TLP both correct.
